// File: rtl/mem_bus_arbiter_2to1.sv
// Round-robin two-master arbiter for the picorv32 native memory bus, one grant per
// transaction, with a sticky watchdog flag for responders that stall too long.
module mem_bus_arbiter_2to1 #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,

  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,

  output logic        s_mem_valid,
  output logic        s_mem_instr,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,

  output logic [1:0]  grant,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  state_t           r_state;
  logic             r_lw;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;

  logic             w_own0;
  logic             w_own1;
  logic             w_sel_valid;
  logic             w_done;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_own0      = (r_state == OWN0);
  assign w_own1      = (r_state == OWN1);
  assign w_sel_valid = (w_own0 & m0_mem_valid) | (w_own1 & m1_mem_valid);
  assign w_cnt_inc   = r_wait_cnt + CNT_W'(1);

  // Reset gates the request and completions combinationally so an abandoned
  // transaction never shows a request or a ready during the reset cycle.
  assign s_mem_valid = w_sel_valid & ~reset;
  assign w_done      = s_mem_valid & s_mem_ready;

  assign m0_mem_ready = w_done & w_own0;
  assign m1_mem_ready = w_done & w_own1;
  assign m0_mem_rdata = m0_mem_ready ? s_mem_rdata : '0;
  assign m1_mem_rdata = m1_mem_ready ? s_mem_rdata : '0;

  assign grant   = {w_own1, w_own0};
  assign timeout = r_timeout;

  always_comb begin
    s_mem_instr = 1'b0;
    s_mem_addr  = '0;
    s_mem_wdata = '0;
    s_mem_wstrb = '0;
    if (w_own0) begin
      s_mem_instr = m0_mem_instr;
      s_mem_addr  = m0_mem_addr;
      s_mem_wdata = m0_mem_wdata;
      s_mem_wstrb = m0_mem_wstrb;
    end else if (w_own1) begin
      s_mem_instr = m1_mem_instr;
      s_mem_addr  = m1_mem_addr;
      s_mem_wdata = m1_mem_wdata;
      s_mem_wstrb = m1_mem_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_lw       <= 1'b1;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wait_cnt <= '0;
          if (m0_mem_valid && m1_mem_valid) r_state <= r_lw ? OWN0 : OWN1;
          else if (m0_mem_valid)            r_state <= OWN0;
          else if (m1_mem_valid)            r_state <= OWN1;
        end
        OWN0, OWN1: begin
          if (!w_sel_valid) begin
            // Owner withdrew its request: release without crediting it a turn.
            r_state    <= IDLE;
            r_wait_cnt <= '0;
          end else if (s_mem_ready) begin
            r_state    <= IDLE;
            r_lw       <= w_own1;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt != MAX_CNT) begin
            r_wait_cnt <= w_cnt_inc;
            if (w_cnt_inc == MAX_CNT) r_timeout <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter_2to1.sv
// Directed bench for mem_bus_arbiter_2to1: transaction-level owner model checked
// every cycle, plus hand-computed expectations for latency, order and timeout.
module tb_mem_bus_arbiter_2to1;

  localparam int MAXW = 16;

  logic        clk;
  logic        reset;
  logic [1:0]        mv, mi;
  logic [1:0][31:0]  ma, mw;
  logic [1:0][3:0]   ms;
  logic        m0_rdy, m1_rdy;
  logic [31:0] m0_rd, m1_rd;
  logic [1:0]        mr;
  logic [1:0][31:0]  mrd;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout;

  assign mr  = {m1_rdy, m0_rdy};
  assign mrd = {m1_rd, m0_rd};

  mem_bus_arbiter_2to1 #(.MAX_WAIT(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .m0_mem_valid(mv[0]), .m0_mem_instr(mi[0]), .m0_mem_addr(ma[0]),
    .m0_mem_wdata(mw[0]), .m0_mem_wstrb(ms[0]), .m0_mem_ready(m0_rdy), .m0_mem_rdata(m0_rd),
    .m1_mem_valid(mv[1]), .m1_mem_instr(mi[1]), .m1_mem_addr(ma[1]),
    .m1_mem_wdata(mw[1]), .m1_mem_wstrb(ms[1]), .m1_mem_ready(m1_rdy), .m1_mem_rdata(m1_rd),
    .s_mem_valid(s_valid), .s_mem_instr(s_instr), .s_mem_addr(s_addr),
    .s_mem_wdata(s_wdata), .s_mem_wstrb(s_wstrb), .s_mem_ready(s_ready), .s_mem_rdata(s_rdata),
    .grant(grant), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  // Model state: owner index (-1 = nobody), last winner, wait count, sticky flag.
  int own = -1;
  int lw = 1;
  int waits = 0;
  bit tmo = 1'b0;

  // Responder knobs and bench logs
  int          lat = 1;
  logic [31:0] rd_val = 32'h0;
  int          order[$];
  logic [1:0]  glog[$];
  logic [1:0]  gprev = 2'b00;
  int          sv_first = -1;
  int          rdy_cnt[2] = '{0, 0};
  bit          t4_on = 1'b0;
  int          t4_bad = 0;
  int          t4_n = 0;
  bit          done4 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        own = -1; lw = 1; waits = 0; tmo = 1'b0;
      end else if (own < 0) begin
        waits = 0;
        if (mv == 2'b11)  own = 1 - lw;
        else if (mv[0])   own = 0;
        else if (mv[1])   own = 1;
      end else if (!mv[own]) begin
        own = -1; waits = 0;
      end else if (s_ready) begin
        lw = own; own = -1; waits = 0;
      end else begin
        if (waits < MAXW) waits++;
        if (waits >= MAXW) tmo = 1'b1;
      end
    end
  endtask

  task automatic compare_loop();
    logic [1:0]  e_grant;
    logic        e_sv, e_si;
    logic [31:0] e_sa, e_sw;
    logic [3:0]  e_ss;
    logic [1:0]  e_rdy;
    forever begin
      @(negedge clk);
      e_grant = (own < 0) ? 2'b00 : 2'(1 << own);
      e_sv    = !reset && own >= 0 && mv[own];
      e_si    = (own >= 0) ? mi[own] : 1'b0;
      e_sa    = (own >= 0) ? ma[own] : 32'h0;
      e_sw    = (own >= 0) ? mw[own] : 32'h0;
      e_ss    = (own >= 0) ? ms[own] : 4'h0;
      e_rdy   = 2'b00;
      if (e_sv && s_ready) e_rdy[own] = 1'b1;
      chk("grant", grant, e_grant);
      chk("s_valid", s_valid, e_sv);
      chk("s_instr", s_instr, e_si);
      chk("s_addr", s_addr, e_sa);
      chk("s_wdata", s_wdata, e_sw);
      chk("s_wstrb", s_wstrb, e_ss);
      chk("m0_ready", m0_rdy, e_rdy[0]);
      chk("m1_ready", m1_rdy, e_rdy[1]);
      chk("m0_rdata", m0_rd, e_rdy[0] ? s_rdata : 32'h0);
      chk("m1_rdata", m1_rd, e_rdy[1] ? s_rdata : 32'h0);
      chk("timeout", timeout, tmo);
      if (m0_rdy) begin order.push_back(0); rdy_cnt[0]++; end
      if (m1_rdy) begin order.push_back(1); rdy_cnt[1]++; end
      if (grant != gprev) glog.push_back(grant);
      gprev = grant;
      if (s_valid && sv_first < 0) sv_first = cyc;
      if (t4_on && grant == 2'b10) begin
        t4_n++;
        if (s_addr != 32'h2000 || s_wdata != 32'h12345678 || s_wstrb != 4'b0011 || s_instr != 1'b0)
          t4_bad++;
      end
    end
  endtask

  task automatic responder_loop();
    int rcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (s_valid) begin
        if (rcnt == lat) begin
          s_ready = 1'b1; s_rdata = rd_val; rcnt = 0;
        end else begin
          s_ready = 1'b0; s_rdata = $urandom; rcnt++;
        end
      end else begin
        s_ready = 1'b0; s_rdata = $urandom; rcnt = 0;
      end
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the edge that ends the grant.
  task automatic txn(input int m, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input logic ins, output logic [31:0] rd, output int nwait,
                     output bit tprev, output bit tat);
    bit got = 1'b0;
    int n = 0;
    mv[m] = 1'b1; ma[m] = a; mw[m] = wd; ms[m] = ws; mi[m] = ins;
    rd = 32'h0; tprev = 1'b0; tat = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (mr[m]) begin got = 1'b1; rd = mrd[m]; tat = timeout; end
      else tprev = timeout;
    end
    nwait = n;
    chk($sformatf("m%0d_completed", m), got, 1'b1);
    @(posedge clk); #1;
    mv[m] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int nw, c0, r0;
    bit tp, ta;
    reset = 1'b1; mv = '0; mi = '0; ma = '0; mw = '0; ms = '0;
    s_ready = 1'b0; s_rdata = 32'h0;
    fork
      model_loop();
      compare_loop();
      responder_loop();
      begin #200000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end
    join_none
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_valid", s_valid, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    @(posedge clk); #1;

    // 1) single m0 read, responder ready one cycle after the request reaches it
    lat = 1; rd_val = 32'hDEADBEEF; c0 = cyc; sv_first = -1;
    txn(0, 32'h100, 32'h0, 4'h0, 1'b0, rd, nw, tp, ta);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_latency", nw, 3);
    chk("t1_svalid_cycle", sv_first, c0 + 1);
    chk("t1_m0_pulses", rdy_cnt[0], 1);
    chk("t1_m1_pulses", rdy_cnt[1], 0);

    // 2) simultaneous requests after reset: m0 first, one idle cycle, then m1
    do_reset();
    lat = 0; rd_val = 32'hA5A5_0001;
    glog.delete(); order.delete();
    fork
      txn(0, 32'h200, 32'h0, 4'h0, 1'b1, rd, nw, tp, ta);
      txn(1, 32'h300, 32'h0, 4'h0, 1'b0, rd, nw, tp, ta);
    join
    @(negedge clk);
    chk("t2_glog_len_ok", glog.size() >= 3, 1'b1);
    if (glog.size() >= 3) begin
      chk("t2_grant0", glog[0], 2'b01);
      chk("t2_grant1", glog[1], 2'b00);
      chk("t2_grant2", glog[2], 2'b10);
    end
    @(posedge clk); #1;

    // 3) both masters continuously requesting: strict alternation starting with m0
    lat = 1; order.delete();
    fork
      for (int k = 0; k < 3; k++) txn(0, 32'h1000 + 32'(k * 4), 32'h0, 4'h0, 1'b0, rd, nw, tp, ta);
      for (int k = 0; k < 3; k++) txn(1, 32'h4000 + 32'(k * 4), 32'h0, 4'h0, 1'b0, rd, nw, tp, ta);
    join
    chk("t3_count", order.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < order.size()) chk($sformatf("t3_owner%0d", k), order[k], k % 2);
    @(posedge clk); #1;

    // 4) m1 write while m0 inputs toggle randomly during the grant
    lat = 2; t4_bad = 0; t4_n = 0; t4_on = 1'b1; done4 = 1'b0;
    fork
      begin
        txn(1, 32'h2000, 32'h12345678, 4'b0011, 1'b0, rd, nw, tp, ta);
        done4 = 1'b1;
      end
      while (!done4) begin
        @(posedge clk); #1;
        if (!done4) begin
          ma[0] = $urandom; mw[0] = $urandom; ms[0] = 4'($urandom); mi[0] = 1'($urandom);
          mv[0] = grant[1] ? 1'($urandom) : 1'b0;
        end
      end
    join
    t4_on = 1'b0; mv[0] = 1'b0;
    chk("t4_bad_cycles", t4_bad, 0);
    chk("t4_grant_cycles", t4_n, 3);
    repeat (2) @(posedge clk); #1;

    // 5) stall for MAX_WAIT cycles, then a fast transaction
    lat = MAXW; rd_val = 32'hCAFE_F00D;
    txn(0, 32'h500, 32'h0, 4'h0, 1'b0, rd, nw, tp, ta);
    chk("t5_latency", nw, MAXW + 2);
    chk("t5_rdata", rd, 32'hCAFEF00D);
    chk("t5_tmo_before", tp, 1'b0);
    chk("t5_tmo_at_ready", ta, 1'b1);
    lat = 0; rd_val = 32'h0000_0042;
    txn(1, 32'h600, 32'h0, 4'h0, 1'b0, rd, nw, tp, ta);
    chk("t5_fast_latency", nw, 2);
    chk("t5_fast_rdata", rd, 32'h42);
    chk("t5_tmo_sticky", ta, 1'b1);
    @(posedge clk); #1;

    // 6) reset while m0 owns the bus and the responder has not answered
    lat = 5; r0 = rdy_cnt[0];
    mv[0] = 1'b1; ma[0] = 32'h700; mw[0] = 32'h0; ms[0] = 4'h0; mi[0] = 1'b0;
    @(posedge clk); #1;
    chk("t6_owned", grant, 2'b01);
    chk("t6_tmo_pre", timeout, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mv[0] = 1'b0;
    @(negedge clk);
    chk("t6_grant", grant, 2'b00);
    chk("t6_s_valid", s_valid, 1'b0);
    chk("t6_timeout", timeout, 1'b0);
    chk("t6_no_ready", rdy_cnt[0], r0);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
